// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: instruction-memory write port (WE/A/WD).
interface uart_imem_loader_if;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    modport master (output WE, A, WD);
    modport slave  (input  WE, A, WD);
endinterface

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: 8N1 UART receiver plus framed loader that writes words into instruction memory.
module uart_imem_loader #(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          MEM_WORDS    = 20,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                rx,
    uart_imem_loader_if.master  mem,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int          CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int          IW   = $clog2(MEM_WORDS + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [7:0]  MAXN = 8'(MEM_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, COUNT, DATA, WRITE} ld_state_t;

    rx_state_t       rx_st;
    ld_state_t       state;
    logic [2:0]      rx_sync;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_i;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_ferr;
    logic [7:0]      n;
    logic [IW-1:0]   idx;
    logic [1:0]      bidx;
    logic [23:0]     wbuf;
    logic            rx_s;
    logic            rx_fall;

    // rx_sync[1] is the synchronized line, rx_sync[2] its previous value for edge detection
    assign rx_s    = rx_sync[1];
    assign rx_fall = ~rx_sync[1] & rx_sync[2];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync  <= 3'b111;
            rx_st    <= RX_IDLE;
            cnt      <= '0;
            bit_i    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[1:0], rx};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            cnt      <= cnt + 1'b1;
            case (rx_st)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_fall) rx_st <= RX_START;
                end
                RX_START: if (cnt == HALF) begin
                    cnt   <= '0;
                    bit_i <= '0;
                    rx_st <= rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (cnt == FULL) begin
                    cnt     <= '0;
                    rx_byte <= {rx_s, rx_byte[7:1]};
                    bit_i   <= bit_i + 1'b1;
                    if (bit_i == 3'd7) rx_st <= RX_STOP;
                end
                RX_STOP: if (cnt == FULL) begin
                    rx_valid <= rx_s;
                    rx_ferr  <= ~rx_s;
                    rx_st    <= RX_IDLE;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            mem.WE <= 1'b0;
            mem.A  <= '0;
            mem.WD <= '0;
            n      <= '0;
            idx    <= '0;
            bidx   <= '0;
            wbuf   <= '0;
        end else begin
            done   <= 1'b0;
            mem.WE <= 1'b0;
            if (rx_ferr) begin
                err <= 1'b1;
                if (busy) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: if (rx_valid && rx_byte == SYNC_BYTE) begin
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                    COUNT: if (rx_valid) begin
                        n    <= rx_byte;
                        idx  <= '0;
                        bidx <= '0;
                        if (rx_byte == 8'd0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (rx_byte > MAXN) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else state <= DATA;
                    end
                    // Word is issued on the 4th byte so WE is high exactly during WRITE
                    DATA: if (rx_valid) begin
                        wbuf <= {rx_byte, wbuf[23:8]};
                        bidx <= bidx + 1'b1;
                        if (bidx == 2'd3) begin
                            mem.WE <= 1'b1;
                            mem.A  <= {{(30-IW){1'b0}}, idx, 2'b00};
                            mem.WD <= {rx_byte, wbuf};
                            state  <= WRITE;
                        end
                    end
                    WRITE: begin
                        idx <= idx + 1'b1;
                        if ({{(8-IW){1'b0}}, idx + IW'(1)} == n) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else state <= DATA;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: randomized UART load stimulus checked against packet-level expected writes.
module tb_uart_imem_loader;
    localparam int CPB = 87;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic busy, done, err;
    int n_cmp = 0, n_bad = 0, we_cnt = 0, done_cnt = 0, busy_cyc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] wq[$];

    uart_imem_loader_if mem();

    uart_imem_loader dut (
        .CLK(CLK), .rst_n(rst_n), .rx(rx), .mem(mem.master),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write must match the next packet-derived {address, word}
    always @(negedge CLK) if (rst_n) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (mem.WE) begin
            we_cnt++;
            chk("we_with_done", done, 0);
            chk("addr_range", mem.A <= 32'd76, 1);
            chk("we_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("write", {mem.A, mem.WD}, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = 1'b1;
        repeat ($urandom_range(0, 10)) @(negedge CLK);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we"}, mem.WE, 0);
        chk({tag, "_a"}, mem.A, 0);
        chk({tag, "_wd"}, mem.WD, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_load(input logic [31:0] ws[$], input string tag);
        int we0, d0;
        we0 = we_cnt;
        d0 = done_cnt;
        send_byte(8'hA5);
        chk({tag, "_busy_hi"}, busy, 1);
        send_byte(8'(ws.size()));
        foreach (ws[i]) begin
            exp_q.push_back({32'(i * 4), ws[i]});
            for (int k = 0; k < 4; k++) send_byte(ws[i][8*k +: 8]);
        end
        chk({tag, "_we_cnt"}, we_cnt - we0, ws.size());
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int we0, d0;
        repeat (3) @(negedge CLK);
        chk_quiet("reset");
        rst_n = 1'b1;
        repeat (2000) @(negedge CLK);
        chk("idle_we", we_cnt, 0);
        chk("idle_done", done_cnt, 0);
        chk("idle_busy", busy_cyc, 0);
        chk("idle_err", err, 0);

        rx = 1'b0;
        repeat (10) @(negedge CLK);
        rx = 1'b1;
        repeat (200) @(negedge CLK);
        chk("glitch_busy", busy_cyc, 0);
        chk("glitch_err", err, 0);

        wq.delete();
        wq.push_back(32'h00000013);
        wq.push_back(32'h00500093);
        do_load(wq, "load2");

        we0 = we_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h15);
        chk("badcnt_err", err, 1);
        chk("badcnt_busy", busy, 0);
        chk("badcnt_done", done_cnt - d0, 0);
        send_byte(8'hA5);
        chk("zero_err_clr", err, 0);
        chk("zero_busy", busy, 1);
        send_byte(8'h00);
        chk("zero_done", done_cnt - d0, 1);
        chk("zero_busy_lo", busy, 0);
        chk("badcnt_we", we_cnt - we0, 0);

        we0 = we_cnt;
        send_byte(8'h55);
        send_byte(8'hFF);
        chk("junk_busy", busy, 0);
        chk("junk_err", err, 0);
        chk("junk_we", we_cnt - we0, 0);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        do_load(wq, "junk_load");

        we0 = we_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(8'($urandom), 1'b0);
        chk("ferr_busy", busy, 0);
        chk("ferr_err", err, 1);
        chk("ferr_we", we_cnt - we0, 0);
        chk("ferr_done", done_cnt - d0, 0);

        send_byte(8'($urandom_range(0, 8'hA4)));
        chk("ferr_sticky", err, 1);
        rand_words($urandom_range(1, 2));
        do_load(wq, "rand_a");

        rand_words(3);
        send_byte(8'hA5);
        send_byte(8'h03);
        foreach (wq[i]) exp_q.push_back({32'(i * 4), wq[i]});
        we0 = we_cnt;
        for (int k = 0; k < 4; k++) send_byte(wq[0][8*k +: 8]);
        chk("midrst_first_we", we_cnt - we0, 1);
        @(negedge CLK);
        #2 rst_n = 1'b0;
        #1 chk_quiet("midrst");
        exp_q.delete();
        repeat (5) @(negedge CLK);
        rst_n = 1'b1;
        rand_words(3);
        do_load(wq, "reload3");

        rand_words($urandom_range(1, 2));
        do_load(wq, "rand_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- UART boot loader that fills the instruction memory over its write port (WE/A/WD).
- Receives 8N1 serial bytes, frames them with a sync/count header and assembles little-endian 32-bit words.
- Issues one single-cycle write per word at consecutive word addresses starting at 0.
- Holds `busy` high during a load so the top level can keep the core in reset.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200).
- MEM_WORDS, 20, number of instruction-memory words; the largest legal load count.
- SYNC_BYTE, 8'hA5, header byte that starts a load.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  UART serial input, idle high; asynchronous to CLK.
- WE  output  1  instruction-memory write enable, one-cycle pulse per word.
- A  output  32  byte address of the write, always word aligned (A[1:0]=0).
- WD  output  32  write data.
- busy  output  1  high while a load is in progress.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - WE=0, A=0, WD=0, busy=0, done=0, err=0.
  - Receiver and loader FSM return to IDLE; synchronizer flops are set to 1.
  - Asserting reset mid-load abandons the load; words already written remain in memory.
- Receiver:
  - rx passes through a 2-flop synchronizer.
  - A falling edge in RX_IDLE starts a bit counter.
  - Start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, treat it as a glitch and return to RX_IDLE with no error.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first, 8 bits.
  - Stop bit is sampled once:
    - High: a byte_valid pulse occurs on the stop-sample cycle.
    - Low: framing error; the byte is discarded and err is set.
  - The receiver returns to RX_IDLE after the stop sample. A back-to-back next start bit must be accepted.
- Loader FSM, states IDLE, COUNT, DATA, WRITE:
  - IDLE:
    - On a byte equal to SYNC_BYTE: clear err, set busy=1, go to COUNT.
    - Any other byte is ignored; err is unchanged.
  - COUNT: latch N = the byte.
    - N=0: done pulse, busy=0, go to IDLE.
    - N>MEM_WORDS: err=1, busy=0, go to IDLE; no writes occur.
    - Otherwise: word index=0, byte index=0, go to DATA.
  - DATA: shift bytes into the word buffer little-endian (byte k goes to bits [8k+7:8k]). After the 4th byte, go to WRITE.
  - WRITE: for exactly one cycle, WE=1, A=index*4, WD=word buffer. Then index++.
    - If index equals N: done pulse on the following cycle, busy=0, go to IDLE.
    - Otherwise: go to DATA.
  - A and WD hold their last values while WE=0.
- Framing error while busy: abort to IDLE, busy=0, err=1, no further writes; partial words are discarded.
- err stays set until the next SYNC_BYTE is received in IDLE, or reset.
- done and WE are never high in the same cycle.
- A never exceeds (MEM_WORDS-1)*4.

Test Plan:
- Reset then idle: rx held at 1 for 2000 cycles -> WE, busy, done and err all 0 throughout.
- Normal load of 2 words: send A5, 02, 13 00 00 00, 93 00 50 00 ->
  - WE pulses twice: A=0, WD=32'h00000013; then A=4, WD=32'h00500093.
  - busy high from the stop bit of A5 until done.
  - One done pulse; err=0.
- Bad count: send A5, 15 (21 > MEM_WORDS) -> err=1, busy=0, no WE; a following A5, 00 -> err cleared, one done pulse, no WE.
- Junk before sync: send 55, FF, then A5, 01, EF BE AD DE -> the junk is ignored; one write with A=0, WD=32'hDEADBEEF.
- Framing error mid-load: A5, 02, then 2 good bytes, then a byte with stop bit 0 -> busy falls, err=1, no WE, no done.
- Reset mid-load: assert rst_n=0 after the first WE of a 3-word load -> all outputs 0 immediately; a subsequent full reload of 3 words completes with 3 WE pulses at A=0, 4, 8.
